// File: rtl/slot_alloc_ctrl_if.sv
// rtl/slot_alloc_ctrl_if.sv - request/response and state-register signals of slot_alloc_ctrl
// Ports: requester side req0/op0/idx0, req1/op1/idx1 -> ack0/ack1/slot_idx/fail;
//        state register side occ -> reg_en/reg_data/reg_sel; status busy/full/empty.
// slave modport: the controller. master modport: requesters plus state register.
interface slot_alloc_ctrl_if;
   logic       req0;
   logic       op0;
   logic [1:0] idx0;
   logic       req1;
   logic       op1;
   logic [1:0] idx1;
   logic [3:0] occ;
   logic       reg_en;
   logic       reg_data;
   logic [1:0] reg_sel;
   logic       ack0;
   logic       ack1;
   logic [1:0] slot_idx;
   logic       fail;
   logic       busy;
   logic       full;
   logic       empty;

   modport slave (
      input  req0, op0, idx0, req1, op1, idx1, occ,
      output reg_en, reg_data, reg_sel, ack0, ack1, slot_idx, fail, busy, full, empty
   );

   modport master (
      output req0, op0, idx0, req1, op1, idx1, occ,
      input  reg_en, reg_data, reg_sel, ack0, ack1, slot_idx, fail, busy, full, empty
   );
endinterface

// File: rtl/slot_alloc_ctrl.sv
// rtl/slot_alloc_ctrl.sv - round-robin slot allocate/release controller for a 4-slot occupancy register
// Ports: clk, rst (sync active-low), bus (slot_alloc_ctrl_if.slave).
//   Two requesters allocate the lowest free slot or release a named slot; one command at a
//   time drives the register write port (reg_en/reg_data/reg_sel); ack/slot_idx/fail answer
//   the served requester. full/empty are combinational from occ; all else is registered.
module slot_alloc_ctrl #(
   parameter int NSLOT = 4,
   parameter int IDXW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   slot_alloc_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic            last_srv_q, last_srv_d;
   logic            win_q, win_d;
   logic            op_q, op_d;
   logic [IDXW-1:0] slot_q, slot_d;

   logic            reg_en_q, reg_en_d;
   logic            reg_data_q, reg_data_d;
   logic [IDXW-1:0] reg_sel_q, reg_sel_d;
   logic            ack0_q, ack0_d;
   logic            ack1_q, ack1_d;
   logic [IDXW-1:0] slot_idx_q, slot_idx_d;
   logic            fail_q, fail_d;
   logic            busy_q, busy_d;

   logic            win_c;
   logic            op_c;
   logic [IDXW-1:0] idx_c;
   logic [IDXW-1:0] free_idx;
   logic            has_free;
   logic [IDXW-1:0] slot_c;
   logic            refuse_c;

   // Lowest free slot: scan downwards so the last hit is the lowest index.
   always_comb begin
      free_idx = '0;
      has_free = 1'b0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (!bus.occ[i]) begin
            has_free = 1'b1;
            free_idx = IDXW'(i);
         end
      end
   end

   // Arbitration and acceptance decode; only used while IDLE.
   always_comb begin
      win_c    = (bus.req0 && bus.req1) ? ~last_srv_q : bus.req1;
      op_c     = win_c ? bus.op1 : bus.op0;
      idx_c    = win_c ? bus.idx1 : bus.idx0;
      slot_c   = op_c ? free_idx : idx_c;
      // Allocate on a full register, or release of a slot that is already free.
      refuse_c = op_c ? ~has_free : ~bus.occ[idx_c];
   end

   always_comb begin
      state_d    = state_q;
      last_srv_d = last_srv_q;
      win_d      = win_q;
      op_d       = op_q;
      slot_d     = slot_q;
      reg_en_d   = 1'b0;
      reg_data_d = 1'b0;
      reg_sel_d  = '0;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      slot_idx_d = '0;
      fail_d     = 1'b0;

      // Outputs are computed for the state being entered so they are valid in that state.
      unique case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               last_srv_d = win_c;
               win_d      = win_c;
               op_d       = op_c;
               slot_d     = slot_c;
               if (refuse_c) begin
                  state_d    = RESP;
                  ack0_d     = ~win_c;
                  ack1_d     = win_c;
                  slot_idx_d = slot_c;
                  fail_d     = 1'b1;
               end else begin
                  state_d    = ISSUE;
                  reg_en_d   = 1'b1;
                  reg_data_d = op_c;
                  reg_sel_d  = slot_c;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Register has had one cycle to update; readback must match the written value.
            state_d    = RESP;
            ack0_d     = ~win_q;
            ack1_d     = win_q;
            slot_idx_d = slot_q;
            fail_d     = (bus.occ[slot_q] != op_q);
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_srv_q <= 1'b1;
         win_q      <= 1'b0;
         op_q       <= 1'b0;
         slot_q     <= '0;
         reg_en_q   <= 1'b0;
         reg_data_q <= 1'b0;
         reg_sel_q  <= '0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         slot_idx_q <= '0;
         fail_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_srv_q <= last_srv_d;
         win_q      <= win_d;
         op_q       <= op_d;
         slot_q     <= slot_d;
         reg_en_q   <= reg_en_d;
         reg_data_q <= reg_data_d;
         reg_sel_q  <= reg_sel_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         slot_idx_q <= slot_idx_d;
         fail_q     <= fail_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.reg_en   = reg_en_q;
   assign bus.reg_data = reg_data_q;
   assign bus.reg_sel  = reg_sel_q;
   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.slot_idx = slot_idx_q;
   assign bus.fail     = fail_q;
   assign bus.busy     = busy_q;
   assign bus.full     = &bus.occ;
   assign bus.empty    = ~|bus.occ;
endmodule

// File: tb/tb_slot_alloc_ctrl.sv
// tb/tb_slot_alloc_ctrl.sv - self-checking bench for slot_alloc_ctrl
module tb_slot_alloc_ctrl;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   slot_alloc_ctrl_if bus ();

   slot_alloc_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic       win;
      logic [1:0] slot;
      logic       fail;
      logic       chk_slot;
   } exp_t;

   typedef struct {
      logic       r0;
      logic       o0;
      logic [1:0] i0;
      logic       r1;
      logic       o1;
      logic [1:0] i1;
      logic [3:0] occ;
      logic       ewin;
      logic [1:0] eslot;
      logic       efail;
      logic       chk_slot;
      logic [3:0] eocc;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[7];

   int total = 0;
   int bad   = 0;
   int cyc_n, n_wr, n_ack, n_busy, last_ack, last_wr;
   int last_wd, last_ws;

   logic [3:0] occ_m;
   logic       pend;
   logic       pd;
   logic [1:0] ps;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: register model updates after the edge, outputs sampled on the falling edge.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc_n++;
      #1;
      if (pend) occ_m[ps] = pd;
      pend    = 1'b0;
      bus.occ = occ_m;
      @(negedge clk);
      if (bus.busy) n_busy++;
      if (bus.reg_en) begin
         n_wr++;
         last_wr = cyc_n;
         pend    = 1'b1;
         pd      = bus.reg_data;
         ps      = bus.reg_sel;
         last_wd = int'(bus.reg_data);
         last_ws = int'(bus.reg_sel);
      end
      if (bus.ack0 || bus.ack1) begin
         n_ack++;
         last_ack = cyc_n;
         check("ack_both", int'(bus.ack0 & bus.ack1), 0);
         if (sb.size() == 0) begin
            check("ack_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            check("ack_who", int'(bus.ack1), int'(e.win));
            check("ack_fail", int'(bus.fail), int'(e.fail));
            if (e.chk_slot) check("ack_slot", int'(bus.slot_idx), int'(e.slot));
         end
      end
   endtask

   task automatic clear_counts();
      cyc_n    = 0;
      n_wr     = 0;
      n_ack    = 0;
      n_busy   = 0;
      last_ack = -1;
      last_wr  = -1;
   endtask

   task automatic run_vec(input vec_t v);
      occ_m   = v.occ;
      bus.occ = v.occ;
      #1;
      check("full", int'(bus.full), int'(v.occ == 4'hF));
      check("empty", int'(bus.empty), int'(v.occ == 4'h0));
      check("busy_idle", int'(bus.busy), 0);
      bus.req0 = v.r0;
      bus.op0  = v.o0;
      bus.idx0 = v.i0;
      bus.req1 = v.r1;
      bus.op1  = v.o1;
      bus.idx1 = v.i1;
      sb.push_back('{win: v.ewin, slot: v.eslot, fail: v.efail, chk_slot: v.chk_slot});
      clear_counts();
      while (n_ack == 0 && cyc_n < 10) tick();
      tick();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tick();
      tick();
      check("ack_count", n_ack, 1);
      check("ack_cycle", last_ack, v.efail ? 1 : 3);
      check("writes", n_wr, v.efail ? 0 : 1);
      check("busy_cycles", n_busy, v.efail ? 1 : 3);
      if (!v.efail) begin
         check("write_cycle", last_wr, 1);
         check("wr_data", last_wd, int'(v.ewin ? v.o1 : v.o0));
         check("wr_sel", last_ws, int'(v.eslot));
      end
      check("occ_after", int'(occ_m), int'(v.eocc));
   endtask

   initial begin
      // r0 o0 i0 r1 o1 i1 occ ewin eslot efail chk_slot eocc
      vecs[0] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0,    1'b0, 2'd0, 1'b0, 1'b1, 4'h1};
      vecs[1] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 4'b1011, 1'b1, 2'd2, 1'b0, 1'b1, 4'hF};
      vecs[2] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'hF,    1'b0, 2'd0, 1'b1, 1'b0, 4'hF};
      vecs[3] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0100};
      vecs[4] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1, 4'h0};
      vecs[5] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b0, 2'd3, 1'b0, 1'b1, 4'h0};
      vecs[6] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0111, 1'b0, 2'd3, 1'b0, 1'b1, 4'hF};

      rst      = 1'b0;
      bus.req0 = 1'b0;
      bus.op0  = 1'b0;
      bus.idx0 = 2'd0;
      bus.req1 = 1'b0;
      bus.op1  = 1'b0;
      bus.idx1 = 2'd0;
      occ_m    = 4'h0;
      bus.occ  = 4'h0;
      pend     = 1'b0;
      pd       = 1'b0;
      ps       = 2'd0;
      last_wd  = 0;
      last_ws  = 0;
      clear_counts();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_reg_en", int'(bus.reg_en), 0);
      check("rst_reg_data", int'(bus.reg_data), 0);
      check("rst_reg_sel", int'(bus.reg_sel), 0);
      check("rst_ack0", int'(bus.ack0), 0);
      check("rst_ack1", int'(bus.ack1), 0);
      check("rst_slot_idx", int'(bus.slot_idx), 0);
      check("rst_fail", int'(bus.fail), 0);
      check("rst_busy", int'(bus.busy), 0);
      rst = 1'b1;
      @(negedge clk);

      // Single-command vectors
      for (int k = 0; k < 7; k++) run_vec(vecs[k]);
      check("sb_drained", sb.size(), 0);

      // Both requesters allocating, held from reset: grants alternate starting with 0
      rst      = 1'b0;
      bus.req0 = 1'b1;
      bus.op0  = 1'b1;
      bus.req1 = 1'b1;
      bus.op1  = 1'b1;
      occ_m    = 4'h0;
      bus.occ  = 4'h0;
      pend     = 1'b0;
      repeat (2) @(negedge clk);
      check("arb_empty", int'(bus.empty), 1);
      rst = 1'b1;
      for (int k = 0; k < 4; k++)
         sb.push_back('{win: k[0], slot: k[1:0], fail: 1'b0, chk_slot: 1'b1});
      sb.push_back('{win: 1'b0, slot: 2'd0, fail: 1'b1, chk_slot: 1'b0});
      clear_counts();
      while (n_ack < 5 && cyc_n < 40) tick();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (3) tick();
      check("arb_acks", n_ack, 5);
      check("arb_writes", n_wr, 4);
      check("arb_occ", int'(occ_m), 15);
      check("arb_full", int'(bus.full), 1);
      check("arb_sb", sb.size(), 0);

      // Reset during WAIT aborts the command without an ack
      occ_m   = 4'h0;
      bus.occ = 4'h0;
      #1;
      bus.req0 = 1'b1;
      bus.op0  = 1'b1;
      clear_counts();
      tick();
      tick();
      rst      = 1'b0;
      bus.req0 = 1'b0;
      tick();
      check("abort_busy", int'(bus.busy), 0);
      check("abort_no_ack_now", n_ack, 0);
      rst = 1'b1;
      repeat (4) tick();
      check("abort_no_ack", n_ack, 0);
      check("abort_writes", n_wr, 1);
      check("abort_occ_kept", int'(occ_m), 1);
      check("abort_busy_end", int'(bus.busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
